// File: rtl/ysyx_22050019_arb_pkg.sv
// Shared definitions for the IFU/LSU AXI4-Lite read arbiter: FSM state
// encodings, master identifiers, AXI response codes and a grant helper.
package ysyx_22050019_arb_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  // Master identifiers, also used as the round-robin pointer value
  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

  // AXI read response codes (forwarded untouched by the arbiter)
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // One-hot grant vector {lsu, ifu} for a given master id
  function automatic logic [1:0] mst_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ysyx_22050019_arb_pick.sv
// Combinational winner selection for the two-master read arbiter.
// Build option YSYX_22050019_ARB_RR_EN: when defined, contention is
// resolved by the round-robin pointer; otherwise LSU always beats IFU.
// A lone requester always wins in either mode.
module ysyx_22050019_arb_pick
  import ysyx_22050019_arb_pkg::*;
(
  input  logic       req_ifu_i,
  input  logic       req_lsu_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

`ifdef YSYX_22050019_ARB_RR_EN
  // Round-robin: the pointed-to master wins when both request
  always_comb begin
    gnt_o = 2'b00;
    if (req_ifu_i && req_lsu_i) begin
      gnt_o = mst_onehot(ptr_i);
    end else if (req_lsu_i) begin
      gnt_o = mst_onehot(MST_LSU);
    end else if (req_ifu_i) begin
      gnt_o = mst_onehot(MST_IFU);
    end
  end
`else
  // Pointer has no meaning with fixed priority
  logic unused_ptr;
  assign unused_ptr = ptr_i;

  // Fixed priority: the load path must progress because the pipeline
  // stalls instruction fetch behind it
  always_comb begin
    gnt_o = 2'b00;
    if (req_lsu_i) begin
      gnt_o = mst_onehot(MST_LSU);
    end else if (req_ifu_i) begin
      gnt_o = mst_onehot(MST_IFU);
    end
  end
`endif

endmodule

// File: rtl/ysyx_22050019_axi_rd_arb.sv
// Two-master (IFU, LSU) to one-slave AXI4-Lite read-channel arbiter.
// One transaction in flight; the grant is held from AR acceptance until
// the R handshake. AR towards the slave is registered, R is passed
// through combinationally to the owner (the slave must hold R stable
// while the owner stalls).
// Build option YSYX_22050019_ARB_RR_EN selects round-robin arbitration
// instead of the default fixed LSU > IFU priority.
// Note: rst_n is an asynchronous, ACTIVE-HIGH reset despite its name.
module ysyx_22050019_axi_rd_arb
  import ysyx_22050019_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  // IFU read master
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  // LSU read master
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  // Shared read slave
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  // Current owner {lsu, ifu}, zero when idle
  output logic [1:0]        grant_o
);

  arb_state_e        state_q;
  logic [ADDR_W-1:0] s_araddr_q;
  logic              s_arvalid_q;
  logic [1:0]        grant_q;
  logic              ptr_q;

  logic [1:0]        pick_gnt;
  logic              in_idle;
  logic              in_data;
  logic              owner_lsu;
  logic              owner_ifu;
  logic              r_hs;

  // Outputs are gated by reset so no handshake is offered while it is held
  assign in_idle   = (state_q == ARB_IDLE) && !rst_n;
  assign in_data   = (state_q == ARB_DATA) && !rst_n;
  assign owner_lsu = grant_q[1];
  assign owner_ifu = grant_q[0];

  ysyx_22050019_arb_pick u_pick (
    .req_ifu_i (ifu_arvalid),
    .req_lsu_i (lsu_arvalid),
    .ptr_i     (ptr_q),
    .gnt_o     (pick_gnt)
  );

  // AR acceptance only in IDLE; the winner sees arready in the same cycle
  assign ifu_arready = in_idle && pick_gnt[0];
  assign lsu_arready = in_idle && pick_gnt[1];

  assign s_araddr  = s_araddr_q;
  assign s_arvalid = s_arvalid_q;
  assign grant_o   = grant_q;

  // R channel pass-through to the owner; the non-owner sees all zeros
  always_comb begin
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    ifu_rresp  = 2'b00;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
    lsu_rresp  = 2'b00;
    s_rready   = 1'b0;
    if (in_data) begin
      if (owner_lsu) begin
        lsu_rvalid = s_rvalid;
        lsu_rdata  = s_rdata;
        lsu_rresp  = s_rresp;
        s_rready   = lsu_rready;
      end else if (owner_ifu) begin
        ifu_rvalid = s_rvalid;
        ifu_rdata  = s_rdata;
        ifu_rresp  = s_rresp;
        s_rready   = ifu_rready;
      end
    end
  end

  assign r_hs = in_data && s_rvalid && s_rready;

  // Transaction FSM with registered AR outputs and grant
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ARB_IDLE;
      s_araddr_q  <= '0;
      s_arvalid_q <= 1'b0;
      grant_q     <= 2'b00;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|pick_gnt) begin
            s_araddr_q  <= pick_gnt[1] ? lsu_araddr : ifu_araddr;
            grant_q     <= pick_gnt;
            s_arvalid_q <= 1'b1;
            state_q     <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (s_arready) begin
            s_arvalid_q <= 1'b0;
            state_q     <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (r_hs) begin
            grant_q <= 2'b00;
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          s_arvalid_q <= 1'b0;
          grant_q     <= 2'b00;
          state_q     <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef YSYX_22050019_ARB_RR_EN
  // After each completed read, priority passes to the other master
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ptr_q <= MST_LSU;
    end else if (r_hs) begin
      ptr_q <= owner_lsu ? MST_IFU : MST_LSU;
    end
  end
`else
  assign ptr_q = MST_LSU;
`endif

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arb.sv
// Directed self-checking bench for the IFU/LSU AXI4-Lite read arbiter.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_ysyx_22050019_axi_rd_arb;

  logic        clk;
  logic        rst_n;
  logic [63:0] ifu_araddr, lsu_araddr, s_araddr;
  logic        ifu_arvalid, ifu_arready, lsu_arvalid, lsu_arready;
  logic [63:0] ifu_rdata, lsu_rdata, s_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, s_rresp, grant_o;
  logic        ifu_rvalid, ifu_rready, lsu_rvalid, lsu_rready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_22050019_axi_rd_arb #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One read transaction. Call right after a falling edge with the
  // requests already driven; returns 1 ns after the falling edge of the
  // first IDLE cycle following the R handshake.
  task automatic txn(input string tag, input bit win_lsu, input logic [63:0] exp_addr,
                     input logic [63:0] data, input logic [1:0] resp, input bit drop,
                     input int stall, input logic [63:0] oth_addr);
    logic [63:0] exp_gnt;
    exp_gnt = win_lsu ? 64'd2 : 64'd1;
    // cycle 0: accept
    #1;
    check({tag, ".arready_win"}, 64'(win_lsu ? lsu_arready : ifu_arready), 64'd1);
    check({tag, ".arready_lose"}, 64'(win_lsu ? ifu_arready : lsu_arready), 64'd0);
    check({tag, ".grant_c0"}, 64'(grant_o), 64'd0);
    check({tag, ".s_arvalid_c0"}, 64'(s_arvalid), 64'd0);
    // cycle 1: address phase
    @(negedge clk);
    if (drop) begin
      if (win_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    end
    #1;
    check({tag, ".s_arvalid_c1"}, 64'(s_arvalid), 64'd1);
    check({tag, ".s_araddr"}, s_araddr, exp_addr);
    check({tag, ".grant_c1"}, 64'(grant_o), exp_gnt);
    check({tag, ".arready_c1"}, 64'({ifu_arready, lsu_arready}), 64'd0);
    // cycle 2: data phase, optionally stalled by the owner
    @(negedge clk);
    s_rvalid = 1'b1;
    s_rdata  = data;
    s_rresp  = resp;
    if (win_lsu) begin lsu_rready = (stall == 0); ifu_rready = (stall != 0); end
    else         begin ifu_rready = (stall == 0); lsu_rready = (stall != 0); end
    if (stall > 0) begin
      if (win_lsu) begin ifu_araddr = oth_addr; ifu_arvalid = 1'b1; end
      else         begin lsu_araddr = oth_addr; lsu_arvalid = 1'b1; end
      for (int i = 0; i < stall; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        check({tag, ".stall_s_rready"}, 64'(s_rready), 64'd0);
        check({tag, ".stall_rvalid"}, 64'(win_lsu ? lsu_rvalid : ifu_rvalid), 64'd1);
        check({tag, ".stall_grant"}, 64'(grant_o), exp_gnt);
        check({tag, ".stall_arready"}, 64'({ifu_arready, lsu_arready}), 64'd0);
      end
      @(negedge clk);
      if (win_lsu) begin lsu_rready = 1'b1; ifu_rready = 1'b0; end
      else         begin ifu_rready = 1'b1; lsu_rready = 1'b0; end
    end
    #1;
    check({tag, ".rvalid_win"}, 64'(win_lsu ? lsu_rvalid : ifu_rvalid), 64'd1);
    check({tag, ".rdata_win"}, win_lsu ? lsu_rdata : ifu_rdata, data);
    check({tag, ".rresp_win"}, 64'(win_lsu ? lsu_rresp : ifu_rresp), 64'(resp));
    check({tag, ".rvalid_lose"}, 64'(win_lsu ? ifu_rvalid : lsu_rvalid), 64'd0);
    check({tag, ".rdata_lose"}, win_lsu ? ifu_rdata : lsu_rdata, 64'd0);
    check({tag, ".s_rready"}, 64'(s_rready), 64'd1);
    // back to IDLE
    @(negedge clk);
    s_rvalid   = 1'b0;
    s_rdata    = '0;
    s_rresp    = 2'b00;
    ifu_rready = 1'b0;
    lsu_rready = 1'b0;
    #1;
    check({tag, ".grant_idle"}, 64'(grant_o), 64'd0);
    check({tag, ".s_arvalid_idle"}, 64'(s_arvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    ifu_araddr = 64'h0; lsu_araddr = 64'h0;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    ifu_rready = 1'b0; lsu_rready = 1'b0;
    s_arready = 1'b1; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;

    // Reset state, with requests present
    #12;
    check("rst.ifu_arready", 64'(ifu_arready), 64'd0);
    check("rst.lsu_arready", 64'(lsu_arready), 64'd0);
    check("rst.s_arvalid", 64'(s_arvalid), 64'd0);
    check("rst.s_araddr", s_araddr, 64'd0);
    check("rst.grant", 64'(grant_o), 64'd0);
    check("rst.s_rready", 64'(s_rready), 64'd0);
    @(negedge clk);
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    rst_n = 1'b0;

    // 1: lone IFU read, minimum latency
    @(negedge clk);
    ifu_araddr = 64'h8000_0000; ifu_arvalid = 1'b1;
    txn("t1_ifu", 1'b0, 64'h8000_0000, 64'h0000_0013_0000_0297, 2'b00, 1'b1, 0, 64'h0);

    // 2: simultaneous requests, LSU first then IFU
    @(negedge clk);
    ifu_araddr = 64'h8000_0004; lsu_araddr = 64'h8000_1000;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    txn("t2_lsu", 1'b1, 64'h8000_1000, 64'h1111_2222_3333_4444, 2'b00, 1'b1, 0, 64'h0);
    txn("t2_ifu", 1'b0, 64'h8000_0004, 64'h5555_6666_7777_8888, 2'b00, 1'b1, 0, 64'h0);

    // 3: continuous contention over four transactions
    @(negedge clk);
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit w;
`ifdef YSYX_22050019_ARB_RR_EN
      w = (i % 2 == 0);
`else
      w = 1'b1;
`endif
      txn($sformatf("t3_%0d", i), w, w ? 64'h8000_1000 : 64'h8000_0004,
          64'hA0A0_0000_0000_0000 + 64'(i), 2'b00, 1'b0, 0, 64'h0);
    end
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;

    // 4: IFU owner stalls 5 cycles while an LSU request waits
    @(negedge clk);
    ifu_araddr = 64'h8000_0008; ifu_arvalid = 1'b1;
    txn("t4_stall", 1'b0, 64'h8000_0008, 64'hDEAD_BEEF_0000_0001, 2'b00, 1'b1, 5, 64'h8000_2000);

    // 5: pending LSU request gets SLVERR forwarded
    txn("t5_slverr", 1'b1, 64'h8000_2000, 64'hCAFE_0000_0000_0005, 2'b10, 1'b1, 0, 64'h0);

    // 6a: reset pulse while in ADDR
    @(negedge clk);
    s_arready = 1'b0;
    lsu_araddr = 64'h8000_3000; lsu_arvalid = 1'b1;
    @(negedge clk);
    lsu_arvalid = 1'b0;
    #1;
    check("t6a.s_arvalid_pre", 64'(s_arvalid), 64'd1);
    #1 rst_n = 1'b1;
    #1;
    check("t6a.s_arvalid_rst", 64'(s_arvalid), 64'd0);
    check("t6a.grant_rst", 64'(grant_o), 64'd0);
    #1 rst_n = 1'b0;

    // 6b: reset pulse while in DATA
    @(negedge clk);
    s_arready = 1'b1;
    lsu_arvalid = 1'b1;
    @(negedge clk);
    lsu_arvalid = 1'b0;
    @(negedge clk);
    s_rvalid = 1'b1; s_rdata = 64'h1234; lsu_rready = 1'b0;
    #1;
    check("t6b.grant_data", 64'(grant_o), 64'd2);
    check("t6b.lsu_rvalid_pre", 64'(lsu_rvalid), 64'd1);
    #1 rst_n = 1'b1;
    #1;
    check("t6b.grant_rst", 64'(grant_o), 64'd0);
    check("t6b.lsu_rvalid_rst", 64'(lsu_rvalid), 64'd0);
    check("t6b.s_arvalid_rst", 64'(s_arvalid), 64'd0);
    #1 rst_n = 1'b0;
    s_rvalid = 1'b0; s_rdata = '0;

    // 6c: normal read after reset release
    @(negedge clk);
    ifu_araddr = 64'h8000_0010; ifu_arvalid = 1'b1;
    txn("t6c_ifu", 1'b0, 64'h8000_0010, 64'h0BAD_F00D_0000_0006, 2'b00, 1'b1, 0, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
